// File: rtl/core_host_sequencer_if.sv
// core_host_sequencer_if: host-side load stream, SRAM host ports, corelet handshake and readback stream
interface core_host_sequencer_if;
  logic         start;
  logic         busy;
  logic         done;
  logic         error;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         cl_sel;
  logic [31:0]  ACT_d;
  logic [6:0]   ACT_addr;
  logic         ACT_cen;
  logic         ACT_wen;
  logic [31:0]  W_d;
  logic [6:0]   W_addr;
  logic         W_cen;
  logic         W_wen;
  logic [3:0]   OP_addr;
  logic         OP_cen;
  logic         OP_wen;
  logic [127:0] OP_q;
  logic         seq_begin;
  logic         seq_done;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  modport master (
    input  start, in_valid, in_data, OP_q, seq_done, out_ready,
    output busy, done, error, in_ready, cl_sel,
           ACT_d, ACT_addr, ACT_cen, ACT_wen,
           W_d, W_addr, W_cen, W_wen,
           OP_addr, OP_cen, OP_wen,
           seq_begin, out_valid, out_data
  );
  modport slave (
    output start, in_valid, in_data, OP_q, seq_done, out_ready,
    input  busy, done, error, in_ready, cl_sel,
           ACT_d, ACT_addr, ACT_cen, ACT_wen,
           W_d, W_addr, W_cen, W_wen,
           OP_addr, OP_cen, OP_wen,
           seq_begin, out_valid, out_data
  );
endinterface

// File: rtl/core_host_sequencer.sv
// core_host_sequencer: loads ACT/W SRAMs, hands them to the corelet for one run, then drains OP SRAM
module core_host_sequencer #(
  parameter int ACT_WORDS = 36,
  parameter int W_WORDS   = 72,
  parameter int OP_WORDS  = 16,
  parameter int TIMEOUT   = 4096
) (
  input logic clk,
  input logic reset,
  core_host_sequencer_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {
    IDLE, LOAD_ACT, LOAD_W, FLUSH, RUN_START, RUN_WAIT, RD_REQ, RD_CAP, RD_OUT, DONE
  } state_t;
  state_t state, state_n;
  logic [6:0] cnt, cnt_n;
  logic [3:0] rcnt, rcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic acc, oh, act_wr, w_wr, last_act, last_w, last_rd, tmo, error_n, out_valid_n;
  logic [127:0] out_data_n;
  assign acc      = bus.in_valid && bus.in_ready;
  assign oh       = bus.out_valid && bus.out_ready;
  assign last_act = cnt == 7'(ACT_WORDS - 1);
  assign last_w   = cnt == 7'(W_WORDS - 1);
  assign last_rd  = rcnt == 4'(OP_WORDS - 1);
  assign tmo      = tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rcnt          <= '0;
      tcnt          <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.cl_sel    <= 1'b1;
      bus.ACT_d     <= '0;
      bus.ACT_addr  <= '0;
      bus.ACT_cen   <= 1'b1;
      bus.ACT_wen   <= 1'b1;
      bus.W_d       <= '0;
      bus.W_addr    <= '0;
      bus.W_cen     <= 1'b1;
      bus.W_wen     <= 1'b1;
      bus.OP_addr   <= '0;
      bus.OP_cen    <= 1'b1;
      bus.OP_wen    <= 1'b1;
      bus.seq_begin <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      rcnt          <= rcnt_n;
      tcnt          <= tcnt_n;
      bus.busy      <= state_n != IDLE;
      bus.done      <= state_n == DONE;
      bus.error     <= error_n;
      bus.in_ready  <= state_n == LOAD_ACT || state_n == LOAD_W;
      bus.cl_sel    <= !(state_n == RUN_START || state_n == RUN_WAIT);
      bus.ACT_d     <= act_wr ? bus.in_data : bus.ACT_d;
      bus.ACT_addr  <= act_wr ? cnt : bus.ACT_addr;
      bus.ACT_cen   <= !act_wr;
      bus.ACT_wen   <= !act_wr;
      bus.W_d       <= w_wr ? bus.in_data : bus.W_d;
      bus.W_addr    <= w_wr ? cnt : bus.W_addr;
      bus.W_cen     <= !w_wr;
      bus.W_wen     <= !w_wr;
      bus.OP_addr   <= state_n == RD_REQ ? rcnt_n : bus.OP_addr;
      bus.OP_cen    <= state_n != RD_REQ;
      bus.OP_wen    <= 1'b1;
      bus.seq_begin <= state_n == RUN_START;
      bus.out_valid <= out_valid_n;
      bus.out_data  <= out_data_n;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (bus.start) state_n = LOAD_ACT;
      LOAD_ACT:  if (acc && last_act) state_n = LOAD_W;
      LOAD_W:    if (acc && last_w) state_n = FLUSH;
      FLUSH:     state_n = RUN_START;
      RUN_START: state_n = RUN_WAIT;
      RUN_WAIT:  state_n = bus.seq_done ? RD_REQ : tmo ? DONE : RUN_WAIT;
      RD_REQ:    state_n = RD_CAP;
      RD_CAP:    state_n = RD_OUT;
      RD_OUT:    if (oh) state_n = last_rd ? DONE : RD_REQ;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  // The load counter is shared by both SRAM phases and restarts at the ACT->W boundary
  always_comb begin
    act_wr      = acc && state == LOAD_ACT;
    w_wr        = acc && state == LOAD_W;
    cnt_n       = (state == IDLE || (act_wr && last_act)) ? '0 : cnt + 7'(acc);
    tcnt_n      = state == RUN_START ? '0 : state == RUN_WAIT ? tcnt + 1'b1 : tcnt;
    rcnt_n      = state == RUN_WAIT ? '0 : (state == RD_OUT && oh) ? rcnt + 4'd1 : rcnt;
    error_n     = (state == IDLE && bus.start) ? 1'b0 :
                  (state == RUN_WAIT && !bus.seq_done && tmo) ? 1'b1 : bus.error;
    out_valid_n = state == RD_CAP ? 1'b1 : (state == RD_OUT && oh) ? 1'b0 : bus.out_valid;
    out_data_n  = state == RD_CAP ? bus.OP_q : bus.out_data;
  end
endmodule

// File: tb/tb_core_host_sequencer.sv
// tb_core_host_sequencer: scenario table plus randomized runs against SRAM/corelet models and expected stream contents
module tb_core_host_sequencer;
  localparam int TIMEOUT = 4096;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  core_host_sequencer_if bus();
  core_host_sequencer #(.ACT_WORDS(36), .W_WORDS(72), .OP_WORDS(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  logic [31:0] act_mem [128];
  logic [31:0] w_mem [128];
  logic [127:0] op_mem [16];
  always @(posedge clk) begin
    if (bus.cl_sel && !bus.ACT_cen && !bus.ACT_wen) act_mem[bus.ACT_addr] <= bus.ACT_d;
    if (bus.cl_sel && !bus.W_cen && !bus.W_wen) w_mem[bus.W_addr] <= bus.W_d;
    if (bus.cl_sel && !bus.OP_cen && bus.OP_wen) bus.OP_q <= op_mem[bus.OP_addr];
  end
  typedef struct {
    int gap;
    int dd;
    int sbeat;
    int slen;
    bit rnd;
    bit exp_err;
  } vec_t;
  vec_t tv [7];
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic reset_vals(input string nm);
    chk({nm, "_ctl"}, {bus.cl_sel, bus.ACT_cen, bus.ACT_wen, bus.W_cen, bus.W_wen, bus.OP_cen, bus.OP_wen}, 7'h7f);
    chk({nm, "_addr"}, {bus.ACT_addr, bus.W_addr, bus.OP_addr}, 0);
    chk({nm, "_d"}, {bus.ACT_d, bus.W_d}, 0);
    chk({nm, "_flags"}, {bus.seq_begin, bus.in_ready, bus.out_valid, bus.done, bus.error, bus.busy}, 0);
    chk({nm, "_out"}, bus.out_data, 0);
  endtask
  task automatic run_seq(input vec_t v);
    logic [31:0] words [108];
    int k, n, t, beat, done_cnt, done_t, sb_extra, bad, stall_left, mm;
    bit hs, vl, stalled;
    for (int i = 0; i < 108; i++) words[i] = v.rnd ? $urandom : (i < 36 ? i : 32'h1000 + i - 36);
    for (int i = 0; i < 16; i++) op_mem[i] = v.rnd ? {$urandom, $urandom, $urandom, $urandom} : {32{4'(i)}};
    @(negedge clk) bus.start = 1;
    @(negedge clk) bus.start = 0;
    chk("start_clears_error", bus.error, 0);
    chk("busy_after_start", bus.busy, 1);
    k = 0;
    n = 0;
    while (k < 108 && n < 3000) begin
      vl = v.gap == 0 ? 1'b1 : v.gap == 1 ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      bus.in_valid = vl;
      bus.in_data = words[k];
      hs = vl && bus.in_ready;
      @(negedge clk);
      n++;
      if (hs) begin
        if (k == 0) chk("first_strobe", {bus.ACT_cen, bus.ACT_wen, bus.ACT_addr, bus.ACT_d}, {2'b00, 7'd0, words[0]});
        k++;
      end
    end
    bus.in_valid = 0;
    chk("load_count", k, 108);
    chk("flush_state", {bus.in_ready, bus.W_cen, bus.seq_begin, bus.cl_sel}, 4'b0001);
    @(negedge clk);
    chk("seq_begin_pulse", {bus.seq_begin, bus.cl_sel}, 2'b10);
    t = 0;
    beat = 0;
    done_cnt = 0;
    done_t = 0;
    sb_extra = 0;
    bad = 0;
    stall_left = 0;
    stalled = 0;
    while (t < 6000) begin
      bus.seq_done = v.dd >= 0 && t == v.dd;
      if (t > 0 && bus.seq_begin) sb_extra++;
      if (bus.done) begin
        done_cnt++;
        done_t = t;
      end
      if (bus.out_valid && beat == v.sbeat && !stalled) begin
        stall_left = v.slen;
        stalled = 1;
      end
      bus.out_ready = stall_left > 0 ? 1'b0 : v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_left > 0) stall_left--;
      if (bus.out_valid && beat < 16) begin
        if (bus.out_ready) begin
          chk("beat", bus.out_data, op_mem[beat]);
          beat++;
        end else if (bus.out_data !== op_mem[beat] || bus.OP_cen !== 1'b1) bad++;
      end else if (bus.out_valid) bad++;
      if (done_cnt > 0 && t > done_t + 3) break;
      @(negedge clk);
      t++;
    end
    bus.seq_done = 0;
    bus.out_ready = 0;
    chk("done_pulses", done_cnt, 1);
    chk("beat_count", beat, v.exp_err ? 0 : 16);
    chk("error_flag", bus.error, v.exp_err);
    chk("seq_begin_once", sb_extra, 0);
    chk("hold_stable", bad, 0);
    if (v.exp_err) chk("timeout_done_cycle", done_t, TIMEOUT + 1);
    mm = 0;
    for (int i = 0; i < 36; i++) if (act_mem[i] !== words[i]) mm++;
    for (int i = 0; i < 72; i++) if (w_mem[i] !== words[36 + i]) mm++;
    chk("sram_contents", mm, 0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, n;
    bit hs;
    tv[0] = '{gap: 0, dd: 50, sbeat: -1, slen: 0, rnd: 0, exp_err: 0};
    tv[1] = '{gap: 1, dd: 50, sbeat: 5, slen: 20, rnd: 0, exp_err: 0};
    tv[2] = '{gap: 0, dd: -1, sbeat: -1, slen: 0, rnd: 0, exp_err: 1};
    tv[3] = '{gap: 0, dd: 0, sbeat: -1, slen: 0, rnd: 0, exp_err: 1};
    tv[4] = '{gap: 2, dd: 1, sbeat: 3, slen: 7, rnd: 1, exp_err: 0};
    tv[5] = '{gap: 2, dd: int'($urandom_range(1, 300)), sbeat: int'($urandom_range(0, 15)), slen: int'($urandom_range(1, 30)), rnd: 1, exp_err: 0};
    tv[6] = '{gap: 2, dd: int'($urandom_range(1, 300)), sbeat: -1, slen: 0, rnd: 1, exp_err: 0};
    bus.start = 0;
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.seq_done = 0;
    bus.out_ready = 0;
    repeat (3) @(negedge clk);
    reset_vals("reset");
    rst = 0;
    @(negedge clk) bus.start = 1;
    @(negedge clk) bus.start = 0;
    bus.in_valid = 1;
    k = 0;
    n = 0;
    while (k < 46 && n < 200) begin
      bus.in_data = 32'hdead0000 + k;
      hs = bus.in_ready;
      @(negedge clk);
      n++;
      if (hs) k++;
    end
    #2 rst = 1;
    #1 reset_vals("mid_reset");
    @(negedge clk);
    bus.in_valid = 0;
    reset_vals("mid_reset_next");
    rst = 0;
    for (int i = 0; i < 7; i++) run_seq(tv[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_host_sequencer.md
Name: core_host_sequencer

Overview:
- Host-side sequencer directly upstream of the core (SRAM banks plus corelet).
- Streams activation and weight words from a valid/ready input into the ACT and W SRAM ports while holding the SRAMs in host mode (cl_sel=1).
- Hands SRAM ownership to the corelet (cl_sel=0), pulses seq_begin and waits for seq_done.
- Retakes ownership and drains the OP SRAM through a valid/ready 128-bit output.

Parameters:
ACT_WORDS, 36, number of 32-bit words written to ACT SRAM (addr 0..ACT_WORDS-1)
W_WORDS, 72, number of 32-bit words written to W SRAM
OP_WORDS, 16, number of 128-bit words read back from OP SRAM
TIMEOUT, 4096, max cycles waited for seq_done before error

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  begin one load/run/readback sequence (sampled in IDLE only)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when sequence ends (success or timeout)
error  out  1  sticky timeout flag, cleared on accepted start
in_valid  in  1  input word valid
in_ready  out  1  high only in LOAD_ACT/LOAD_W
in_data  in  32  input word (ACT words first, then W words)
cl_sel  out  1  SRAM owner select: 1=host (this block), 0=corelet
ACT_d/ACT_addr/ACT_cen/ACT_wen  out  32/7/1/1  ACT SRAM host port
W_d/W_addr/W_cen/W_wen  out  32/7/1/1  W SRAM host port
OP_addr/OP_cen/OP_wen  out  4/1/1  OP SRAM host port
OP_q  in  128  OP SRAM read data
seq_begin  out  1  one-cycle run request to corelet
seq_done  in  1  corelet completion
out_valid  out  1  readback word valid
out_ready  in  1  downstream accepts readback word
out_data  out  128  readback word

Behaviour:
- All outputs registered.
- Reset values: cl_sel=1; all cen=1 and wen=1; addrs=0; d=0; seq_begin=0; in_ready=0; out_valid=0; out_data=0; done=0; error=0; busy=0; state IDLE.
- Reset mid-operation: aborts immediately to the reset values; partially written SRAM contents are left as-is.
- SRAM convention: cen and wen active-low; a write occurs on the edge where cen=0 and wen=0; read data on OP_q is valid the cycle after cen=0 with wen=1.
- IDLE: on start=1, load-word counter <= 0, error <= 0, go to LOAD_ACT. start is ignored in all other states.
- LOAD_ACT: in_ready=1. On each in_valid&&in_ready, next cycle drive ACT_cen=0, ACT_wen=0, ACT_d=in_data, ACT_addr=counter; counter increments. Otherwise ACT_cen=1.
  - After the ACT_WORDS-th accepted word: counter <= 0, go to LOAD_W.
  - in_valid gaps are allowed.
- LOAD_W: same as LOAD_ACT using the W port. After the W_WORDS-th word go to FLUSH.
- FLUSH (1 cycle): cl_sel stays 1 so the final W write completes; in_ready=0.
- RUN_START (1 cycle): cl_sel=0, seq_begin=1, timeout counter <= 0.
- RUN_WAIT:
  - cl_sel=0, seq_begin=0.
  - seq_done is sampled from the first RUN_WAIT cycle on. On seq_done=1, go to RD_REQ with read counter 0.
  - Otherwise the timeout counter increments. At TIMEOUT with no seq_done: error <= 1, go to DONE.
  - seq_done=1 during RUN_START is ignored.
- RD_REQ: cl_sel=1, OP_cen=0, OP_wen=1, OP_addr=read counter.
- RD_CAP: OP_cen=1; out_data <= OP_q; out_valid <= 1.
- RD_OUT: hold out_data and out_valid until out_ready=1. On the handshake out_valid <= 0 and the read counter increments.
  - Next state is RD_REQ, or DONE after word OP_WORDS-1.
  - out_data must not change while out_valid=1.
- DONE: done=1 for one cycle, cl_sel=1, then IDLE.
- Widths: ACT/W counters are 7 bits and wrap is impossible because WORDS ≤ 128. The OP counter is 4 bits. The timeout counter is clog2(TIMEOUT+1) bits.
- Throughput: 1 input word/cycle during loads; 3 cycles minimum per readback word.

Test Plan:
- Reset during LOAD_W after 10 W words -> next cycle all outputs at reset values, state IDLE; a fresh start reloads from ACT addr 0.
- start, stream 108 words with in_valid always 1 (ACT words 0x00000000..0x00000023, W 0x1000+i) -> ACT addr k holds k, W addr k holds 0x1000+k.
  - First write strobe appears 1 cycle after the first handshake.
  - seq_begin pulses exactly once, 2 cycles after the last handshake, with cl_sel=0.
- in_valid toggled every other cycle during load -> same SRAM contents; in_ready drops the cycle after the 108th handshake.
- seq_done asserted 50 cycles after seq_begin, OP SRAM preloaded with word i = {32{i[3:0]}}, out_ready=1 -> 16 out_valid beats, beat i = {32{i}}; done pulses once; error=0.
- out_ready held 0 for 20 cycles on beat 5 -> out_data stable at beat 5 value, OP_cen=1 throughout, no skipped or duplicated beats.
- seq_done never asserted -> error=1 and done pulse TIMEOUT+1 cycles after seq_begin, no readback beats; next start clears error.
